if_stage: RTL and testbench

Instruction-fetch stage for the pipelined RV32I core, sitting directly upstream of decode. It owns the program counter, issues word reads to a 1-cycle-latency synchronous instruction memory, and buffers returned instructions in a 2-entry skid FIFO. Decode consumes instructions through a valid/ready handshake. Branch/jump redirects from EX flush all buffered and in-flight fetches.

---
 rtl/if_stage_if.sv | 24 ++
 rtl/if_stage.sv | 82 ++++++++
 tb/tb_if_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory read port, EX redirect and the
// valid/ready handoff to decode. The master side is the fetch stage itself.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4,
        input  imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4,
        output imem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction fetch: owns the PC, issues reads to a 1-cycle synchronous
// imem and parks returned words in a 2-entry shift FIFO feeding decode.
// Requests are only issued when a slot is guaranteed for the response, so
// the FIFO can never overflow.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t [1:0] fifo_q, fifo_n;
    logic   [1:0] count_q, count_n;
    logic         infl_q;
    logic  [31:0] infl_pc_q;
    logic  [31:0] fetch_pc_q;

    logic         head_vld;
    logic         pop;
    logic         issue;
    logic   [2:0] occ;

    assign head_vld = (count_q != 2'd0);
    assign pop      = head_vld && bus.id_ready;
    // Slots already claimed: buffered entries plus the response on its way.
    assign occ      = {1'b0, count_q} + {2'b00, infl_q};
    assign issue    = !rst && !bus.redirect && ((occ < 3'd2) || pop);

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q;

    // Head of FIFO drives decode; outputs forced to NOP/0 when empty.
    assign bus.id_valid = head_vld;
    assign bus.id_instr = head_vld ? fifo_q[0].instr : NOP;
    assign bus.id_pc    = head_vld ? fifo_q[0].pc : 32'h0;
    assign bus.id_pc4   = head_vld ? (fifo_q[0].pc + 32'd4) : 32'h0;

    // Next FIFO contents: pop shifts entry 1 down, then the response lands
    // behind whatever remains so order is preserved on push+pop.
    always_comb begin
        fifo_n  = fifo_q;
        count_n = count_q;
        if (pop) begin
            fifo_n[0] = fifo_q[1];
            count_n   = count_q - 2'd1;
        end
        if (infl_q) begin
            fifo_n[count_n[0]] = '{pc: infl_pc_q, instr: bus.imem_rdata};
            count_n            = count_n + 2'd1;
        end
    end

    // PC, in-flight tracking and FIFO state; redirect overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            infl_q     <= 1'b0;
            infl_pc_q  <= 32'h0;
            count_q    <= 2'd0;
            fifo_q     <= '0;
        end else if (bus.redirect) begin
            fetch_pc_q <= {bus.redirect_pc[31:2], 2'b00};
            infl_q     <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (issue) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
                infl_pc_q  <= fetch_pc_q;
            end
            infl_q  <= issue;
            count_q <= count_n;
            fifo_q  <= fifo_n;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage. The reference model tracks the program
// order decode must see (next expected PC), the fetch address stream and the
// number of occupied/claimed buffer slots; imem is modelled as a function of
// the word address.
module tb_if_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_stage_if bus();
    if_stage #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    int          occ;
    int          infl;
    logic [31:0] exp_pc;
    logic [31:0] fetch_m;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // 1-cycle synchronous instruction memory; junk when not requested.
    always @(posedge clk)
        bus.imem_rdata <= bus.imem_req ? memf(bus.imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        occ     = 0;
        infl    = 0;
        exp_pc  = 32'h0;
        fetch_m = 32'h0;
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic cyc(input logic rdy, input logic rd, input logic [31:0] rpc);
        bit pop, req_e;
        bus.id_ready    = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        #4;
        chk("id_valid", {31'b0, bus.id_valid}, {31'b0, occ > 0});
        if (occ > 0) begin
            chk("id_pc", bus.id_pc, exp_pc);
            chk("id_instr", bus.id_instr, memf(exp_pc));
            chk("id_pc4", bus.id_pc4, exp_pc + 32'd4);
        end else begin
            chk("idle_instr", bus.id_instr, 32'h0000_0013);
            chk("idle_pc", bus.id_pc, 32'h0);
            chk("idle_pc4", bus.id_pc4, 32'h0);
        end
        pop   = (occ > 0) && rdy;
        req_e = !rd && ((occ + infl < 2) || pop);
        chk("imem_req", {31'b0, bus.imem_req}, {31'b0, req_e});
        if (req_e) chk("imem_addr", bus.imem_addr, fetch_m);
        if (pop) exp_pc = exp_pc + 32'd4;
        if (rd) begin
            occ     = 0;
            infl    = 0;
            fetch_m = {rpc[31:2], 2'b00};
            exp_pc  = fetch_m;
        end else begin
            occ = occ + infl - (pop ? 1 : 0);
            chk("fifo_ovf", {31'b0, occ <= 2}, 32'd1);
            if (req_e) fetch_m = fetch_m + 32'd4;
            infl = req_e ? 1 : 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear before any edge.
    task automatic rst_mid();
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", {31'b0, bus.id_valid}, 32'h0);
        chk("rst_instr", bus.id_instr, 32'h0000_0013);
        chk("rst_pc", bus.id_pc, 32'h0);
        chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] edge_pc [4];
        edge_pc[0] = 32'hFFFF_FFF8;
        edge_pc[1] = 32'h0000_0203;
        edge_pc[2] = 32'h0000_0200;
        edge_pc[3] = 32'hFFFF_FFFF;

        bus.id_ready    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        model_reset();
        #2;
        chk("por_valid", {31'b0, bus.id_valid}, 32'h0);
        chk("por_instr", bus.id_instr, 32'h0000_0013);
        chk("por_req", {31'b0, bus.imem_req}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // cold start, full throughput
        repeat (20) cyc(1'b1, 1'b0, 32'h0);
        // decode stall then resume
        repeat (5)  cyc(1'b0, 1'b0, 32'h0);
        repeat (10) cyc(1'b1, 1'b0, 32'h0);
        // redirect with buffered and in-flight work
        repeat (2)  cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h0000_0200);
        repeat (8)  cyc(1'b1, 1'b0, 32'h0);
        // redirect coinciding with a pop, unaligned target
        cyc(1'b1, 1'b1, 32'h0000_0203);
        repeat (8)  cyc(1'b1, 1'b0, 32'h0);
        // address wrap
        cyc(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (8)  cyc(1'b1, 1'b0, 32'h0);
        // async reset with a full buffer
        repeat (4)  cyc(1'b0, 1'b0, 32'h0);
        rst_mid();
        repeat (10) cyc(1'b1, 1'b0, 32'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        rdy, rd;
            logic [31:0] rpc;
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 24) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? edge_pc[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 399) == 0) rst_mid();
            else cyc(rdy, rd, rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
